// File: rtl/obstacle_pixel_mapper.sv
// obstacle_pixel_mapper
// Maps scanned screen pixels through a per-frame camera offset onto a
// double-buffered table of obstacle rectangles and emits the per-pixel
// obstacle bundle (hit flag, ROM coordinates, absolute positions).
// Two-cycle latency: S1 forms world coordinates, S2 resolves hits.
// Optional macro OBSTACLE_HIT_COUNT_EN adds a per-frame hit-pixel counter.
module obstacle_pixel_mapper #(
    parameter int SCREEN_WIDTH    = 10,
    parameter int PHY_WIDTH       = 16,
    parameter int OBSTACLE_WIDTH  = 10,
    parameter int BLOCK_LEN_WIDTH = 4,
    parameter int OBSTACLE_NUM    = 8,
    parameter int IDX_WIDTH       = 3
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       frame_start,
    input  logic [PHY_WIDTH-1:0]       cam_x,
    input  logic [PHY_WIDTH-1:0]       cam_y,
    input  logic [SCREEN_WIDTH-1:0]    pixel_x,
    input  logic [SCREEN_WIDTH-1:0]    pixel_y,
    input  logic                       pixel_valid,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [IDX_WIDTH-1:0]       wr_idx,
    input  logic [PHY_WIDTH-1:0]       wr_abs_x,
    input  logic [PHY_WIDTH-1:0]       wr_abs_y,
    input  logic [BLOCK_LEN_WIDTH-1:0] wr_len,
    output logic                       obstacle_on,
    output logic [SCREEN_WIDTH-1:0]    obstacle_x_rom,
    output logic [SCREEN_WIDTH-1:0]    obstacle_y_rom,
    output logic [PHY_WIDTH-1:0]       obstacle_block_abs_y,
    output logic [PHY_WIDTH-1:0]       obstacle_abs_pos_x,
    output logic [PHY_WIDTH-1:0]       obstacle_abs_pos_y,
    output logic [15:0]                hit_count
);

    // Edge offsets carry one extra bit so rectangles near the top of the
    // world coordinate range never wrap around to zero.
    localparam logic [PHY_WIDTH:0] BLK_W = (PHY_WIDTH+1)'(OBSTACLE_WIDTH);
    localparam logic [PHY_WIDTH:0] BLK_H = (PHY_WIDTH+1)'(2 * OBSTACLE_WIDTH);

    logic                 wr_fire;
    logic [PHY_WIDTH-1:0] cam_x_reg, cam_y_reg;
    logic [PHY_WIDTH-1:0] world_x_s1_reg, world_y_s1_reg;
    logic                 valid_s1_reg;

    logic [OBSTACLE_NUM-1:0] hit;
    logic [PHY_WIDTH-1:0]    ent_abs_x [OBSTACLE_NUM];
    logic [PHY_WIDTH-1:0]    ent_abs_y [OBSTACLE_NUM];

    logic                    any_hit;
    logic [PHY_WIDTH-1:0]    sel_abs_x, sel_abs_y;

    logic                    on_reg;
    logic [SCREEN_WIDTH-1:0] x_rom_reg, y_rom_reg;
    logic [PHY_WIDTH-1:0]    block_abs_y_reg, abs_pos_x_reg, abs_pos_y_reg;

    // Writes stall only on the commit cycle so the copied snapshot is stable.
    assign wr_ready = ~frame_start;
    assign wr_fire  = wr_valid & wr_ready;

    genvar gi;
    generate
        for (gi = 0; gi < OBSTACLE_NUM; gi++) begin : g_entry
            logic [PHY_WIDTH-1:0]       shd_abs_x_reg, shd_abs_y_reg;
            logic [BLOCK_LEN_WIDTH-1:0] shd_len_reg;
            logic [PHY_WIDTH-1:0]       act_abs_x_reg, act_abs_y_reg;
            logic [BLOCK_LEN_WIDTH-1:0] act_len_reg;
            logic [PHY_WIDTH:0]         right_edge, bottom_edge;

            // Shadow entry takes game-logic writes; active entry snapshots it at frame start.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    shd_abs_x_reg <= '0;
                    shd_abs_y_reg <= '0;
                    shd_len_reg   <= '0;
                    act_abs_x_reg <= '0;
                    act_abs_y_reg <= '0;
                    act_len_reg   <= '0;
                end else begin
                    if (wr_fire && (wr_idx == IDX_WIDTH'(gi))) begin
                        shd_abs_x_reg <= wr_abs_x;
                        shd_abs_y_reg <= wr_abs_y;
                        shd_len_reg   <= wr_len;
                    end
                    if (frame_start) begin
                        act_abs_x_reg <= shd_abs_x_reg;
                        act_abs_y_reg <= shd_abs_y_reg;
                        act_len_reg   <= shd_len_reg;
                    end
                end
            end

            assign right_edge  = {1'b0, act_abs_x_reg} + (PHY_WIDTH+1)'(act_len_reg) * BLK_W;
            assign bottom_edge = {1'b0, act_abs_y_reg} + BLK_H;

            assign hit[gi] = (act_len_reg != '0)
                           && (world_x_s1_reg >= act_abs_x_reg)
                           && ({1'b0, world_x_s1_reg} < right_edge)
                           && (world_y_s1_reg >= act_abs_y_reg)
                           && ({1'b0, world_y_s1_reg} < bottom_edge);

            assign ent_abs_x[gi] = act_abs_x_reg;
            assign ent_abs_y[gi] = act_abs_y_reg;
        end
    endgenerate

    // Camera offset is latched once per frame alongside the table commit.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cam_x_reg <= '0;
            cam_y_reg <= '0;
        end else if (frame_start) begin
            cam_x_reg <= cam_x;
            cam_y_reg <= cam_y;
        end
    end

    // S1: screen pixel to world coordinates, wrapping modulo 2^PHY_WIDTH.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            world_x_s1_reg <= '0;
            world_y_s1_reg <= '0;
            valid_s1_reg   <= 1'b0;
        end else begin
            world_x_s1_reg <= cam_x_reg + PHY_WIDTH'(pixel_x);
            world_y_s1_reg <= cam_y_reg + PHY_WIDTH'(pixel_y);
            valid_s1_reg   <= pixel_valid;
        end
    end

    // Priority select: scanning downward lets the lowest hit index win.
    always_comb begin
        sel_abs_x = '0;
        sel_abs_y = '0;
        for (int i = OBSTACLE_NUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_abs_x = ent_abs_x[i];
                sel_abs_y = ent_abs_y[i];
            end
        end
        any_hit = |hit;
    end

    // S2: register the pixel bundle; ROM offsets only need the low bits of the difference.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            on_reg          <= 1'b0;
            x_rom_reg       <= '0;
            y_rom_reg       <= '0;
            block_abs_y_reg <= '0;
            abs_pos_x_reg   <= '0;
            abs_pos_y_reg   <= '0;
        end else begin
            block_abs_y_reg <= world_y_s1_reg;
            if (valid_s1_reg && any_hit) begin
                on_reg        <= 1'b1;
                x_rom_reg     <= world_x_s1_reg[SCREEN_WIDTH-1:0] - sel_abs_x[SCREEN_WIDTH-1:0];
                y_rom_reg     <= world_y_s1_reg[SCREEN_WIDTH-1:0] - sel_abs_y[SCREEN_WIDTH-1:0];
                abs_pos_x_reg <= sel_abs_x;
                abs_pos_y_reg <= sel_abs_y;
            end else begin
                on_reg        <= 1'b0;
                x_rom_reg     <= '0;
                y_rom_reg     <= '0;
                abs_pos_x_reg <= '0;
                abs_pos_y_reg <= '0;
            end
        end
    end

    assign obstacle_on          = on_reg;
    assign obstacle_x_rom       = x_rom_reg;
    assign obstacle_y_rom       = y_rom_reg;
    assign obstacle_block_abs_y = block_abs_y_reg;
    assign obstacle_abs_pos_x   = abs_pos_x_reg;
    assign obstacle_abs_pos_y   = abs_pos_y_reg;

`ifdef OBSTACLE_HIT_COUNT_EN
    logic [15:0] hit_cnt_reg, hit_count_reg;

    // Saturating per-frame hit counter; a hit on the commit cycle opens the new frame's count.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hit_cnt_reg   <= '0;
            hit_count_reg <= '0;
        end else if (frame_start) begin
            hit_count_reg <= hit_cnt_reg;
            hit_cnt_reg   <= {15'd0, on_reg};
        end else if (on_reg && (hit_cnt_reg != 16'hFFFF)) begin
            hit_cnt_reg <= hit_cnt_reg + 16'd1;
        end
    end

    assign hit_count = hit_count_reg;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_obstacle_pixel_mapper.sv
// Directed testbench for obstacle_pixel_mapper. Inputs change and outputs
// are sampled on the falling clock edge; expected values are hand-computed.
module tb_obstacle_pixel_mapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] cam_x = '0, cam_y = '0;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic        pixel_valid = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_idx = '0;
    logic [15:0] wr_abs_x = '0, wr_abs_y = '0;
    logic [3:0]  wr_len = '0;
    logic        obstacle_on;
    logic [9:0]  obstacle_x_rom, obstacle_y_rom;
    logic [15:0] obstacle_block_abs_y, obstacle_abs_pos_x, obstacle_abs_pos_y;
    logic [15:0] hit_count;

    int n_checks = 0;
    int n_pass   = 0;

    obstacle_pixel_mapper dut (
        .sys_clk              (clk),
        .sys_rst              (rst),
        .frame_start          (frame_start),
        .cam_x                (cam_x),
        .cam_y                (cam_y),
        .pixel_x              (pixel_x),
        .pixel_y              (pixel_y),
        .pixel_valid          (pixel_valid),
        .wr_valid             (wr_valid),
        .wr_ready             (wr_ready),
        .wr_idx               (wr_idx),
        .wr_abs_x             (wr_abs_x),
        .wr_abs_y             (wr_abs_y),
        .wr_len               (wr_len),
        .obstacle_on          (obstacle_on),
        .obstacle_x_rom       (obstacle_x_rom),
        .obstacle_y_rom       (obstacle_y_rom),
        .obstacle_block_abs_y (obstacle_block_abs_y),
        .obstacle_abs_pos_x   (obstacle_abs_pos_x),
        .obstacle_abs_pos_y   (obstacle_abs_pos_y),
        .hit_count            (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".on"},    32'(obstacle_on), 32'd0);
        check({tag, ".xrom"},  32'(obstacle_x_rom), 32'd0);
        check({tag, ".yrom"},  32'(obstacle_y_rom), 32'd0);
        check({tag, ".absy"},  32'(obstacle_block_abs_y), 32'd0);
        check({tag, ".posx"},  32'(obstacle_abs_pos_x), 32'd0);
        check({tag, ".posy"},  32'(obstacle_abs_pos_y), 32'd0);
        check({tag, ".hcnt"},  32'(hit_count), 32'd0);
        check({tag, ".ready"}, 32'(wr_ready), 32'd1);
    endtask

    task automatic write_entry(input logic [2:0] idx, input logic [15:0] ax, input logic [15:0] ay,
                               input logic [3:0] len);
        wr_valid = 1'b1; wr_idx = idx; wr_abs_x = ax; wr_abs_y = ay; wr_len = len;
        @(negedge clk);
        wr_valid = 1'b0;
        $display("write idx=%0d abs=(%0d,%0d) len=%0d", idx, ax, ay, len);
    endtask

    task automatic commit(input logic [15:0] cx, input logic [15:0] cy);
        frame_start = 1'b1; cam_x = cx; cam_y = cy;
        @(negedge clk);
        frame_start = 1'b0;
        $display("frame_start cam=(%0h,%0h)", cx, cy);
    endtask

    task automatic run_pixel(input string tag, input logic [9:0] px, input logic [9:0] py,
                             input logic exp_on, input logic [9:0] exp_xr, input logic [9:0] exp_yr,
                             input logic [15:0] exp_px, input logic [15:0] exp_py,
                             input logic [15:0] exp_by);
        pixel_x = px; pixel_y = py; pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        @(negedge clk);
        $display("pixel %s (%0d,%0d) -> on=%0d xrom=%0d yrom=%0d pos=(%0h,%0h) absy=%0h", tag, px, py,
                 obstacle_on, obstacle_x_rom, obstacle_y_rom, obstacle_abs_pos_x, obstacle_abs_pos_y,
                 obstacle_block_abs_y);
        check({tag, ".on"},   32'(obstacle_on), 32'(exp_on));
        check({tag, ".xrom"}, 32'(obstacle_x_rom), 32'(exp_xr));
        check({tag, ".yrom"}, 32'(obstacle_y_rom), 32'(exp_yr));
        check({tag, ".posx"}, 32'(obstacle_abs_pos_x), 32'(exp_px));
        check({tag, ".posy"}, 32'(obstacle_abs_pos_y), 32'(exp_py));
        check({tag, ".absy"}, 32'(obstacle_block_abs_y), 32'(exp_by));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single 3-block obstacle at x 100..129, y 200..219.
        write_entry(3'd0, 16'd100, 16'd200, 4'd3);
        commit(16'd0, 16'd190);
        run_pixel("inside",   10'd105, 10'd15, 1'b1, 10'd5,  10'd5,  16'd100, 16'd200, 16'd205);
        run_pixel("right_out",10'd130, 10'd15, 1'b0, 10'd0,  10'd0,  16'd0,   16'd0,   16'd205);
        run_pixel("corner",   10'd129, 10'd29, 1'b1, 10'd29, 10'd19, 16'd100, 16'd200, 16'd219);
        run_pixel("below",    10'd129, 10'd30, 1'b0, 10'd0,  10'd0,  16'd0,   16'd0,   16'd220);

        // idx0 disabled: idx1 covers 100..109, idx2 covers 110..129.
        write_entry(3'd0, 16'd0,   16'd0,   4'd0);
        write_entry(3'd2, 16'd110, 16'd200, 4'd2);
        write_entry(3'd1, 16'd100, 16'd200, 4'd1);
        commit(16'd0, 16'd190);
        run_pixel("idx2",     10'd112, 10'd15, 1'b1, 10'd2,  10'd5,  16'd110, 16'd200, 16'd205);
        run_pixel("idx1",     10'd105, 10'd15, 1'b1, 10'd5,  10'd5,  16'd100, 16'd200, 16'd205);
        run_pixel("idx2_end", 10'd130, 10'd15, 1'b0, 10'd0,  10'd0,  16'd0,   16'd0,   16'd205);

        // idx0 re-enabled overlaps idx2; the lower index must win.
        write_entry(3'd0, 16'd100, 16'd200, 4'd3);
        commit(16'd0, 16'd190);
        run_pixel("prio",     10'd112, 10'd15, 1'b1, 10'd12, 10'd5,  16'd100, 16'd200, 16'd205);

        // Shadow write without commit is invisible until frame_start.
        write_entry(3'd3, 16'd300, 16'd200, 4'd1);
        run_pixel("idx3_pend",10'd305, 10'd15, 1'b0, 10'd0,  10'd0,  16'd0,   16'd0,   16'd205);
        commit(16'd0, 16'd190);
        run_pixel("idx3_live",10'd305, 10'd15, 1'b1, 10'd5,  10'd5,  16'd300, 16'd200, 16'd205);

        // Write held across the commit cycle: stalled, lands one cycle later.
        frame_start = 1'b1; cam_x = 16'd0; cam_y = 16'd190;
        wr_valid = 1'b1; wr_idx = 3'd4; wr_abs_x = 16'd400; wr_abs_y = 16'd200; wr_len = 4'd1;
        #1;
        check("stall.ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        check("resume.ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        $display("write idx=4 held across frame_start");
        run_pixel("idx4_pend",10'd405, 10'd15, 1'b0, 10'd0,  10'd0,  16'd0,   16'd0,   16'd205);
        commit(16'd0, 16'd190);
        run_pixel("idx4_live",10'd405, 10'd15, 1'b1, 10'd5,  10'd5,  16'd400, 16'd200, 16'd205);

        // 30 hit pixels in one frame, then close the frame.
        commit(16'd0, 16'd190);
        for (int i = 0; i < 30; i++) begin
            pixel_x = 10'd105; pixel_y = 10'd15; pixel_valid = 1'b1;
            @(negedge clk);
        end
        pixel_valid = 1'b0;
        repeat (3) @(negedge clk);
        commit(16'd0, 16'd190);
`ifdef OBSTACLE_HIT_COUNT_EN
        check("hit_count", 32'(hit_count), 32'd30);
`else
        check("hit_count", 32'(hit_count), 32'd0);
`endif

        // Entry near the top of world x: right edge must not wrap to low x.
        write_entry(3'd5, 16'hFFF0, 16'd200, 4'd2);
        commit(16'hFFE0, 16'd190);
        run_pixel("wrap_lo",  10'd16, 10'd15, 1'b1, 10'd0,  10'd5,  16'hFFF0, 16'd200, 16'd205);
        run_pixel("wrap_top", 10'd31, 10'd15, 1'b1, 10'd15, 10'd5,  16'hFFF0, 16'd200, 16'd205);
        run_pixel("wrap_out", 10'd35, 10'd15, 1'b0, 10'd0,  10'd0,  16'd0,    16'd0,   16'd205);

        // Reset asserted with a hit pixel in flight clears everything at once.
        pixel_x = 10'd16; pixel_y = 10'd15; pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        @(negedge clk);
        check_cleared("midrst_hold");
        rst = 1'b0;
        @(negedge clk);
        $display("reset pulse mid-frame");
        commit(16'hFFE0, 16'd190);
        run_pixel("post_rst", 10'd16, 10'd15, 1'b0, 10'd0,  10'd0,  16'd0,    16'd0,   16'd205);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
